counter_arbiter: RTL and testbench
==================================

// Module: counter_arbiter
// PURPOSE
//  Shares one up-counter between NREQ requesters, each asking to time an interval.
//  Round-robin arbitration; the winner owns the counter until its interval
//  expires or it withdraws.
//  Sits between the requesting control FSMs and the counter datapath.
//  Sequences the counter's clear/enable; the counter value is exported for observation.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  WIDTH  4  counter / interval-length width in bits
// PORTS
//  clock      in   1            single clock, all state on posedge
//  reset      in   1            asynchronous, active-low reset
//  req        in   NREQ         per-requester request, level
//  len        in   NREQ*WIDTH   requester i's interval in len[i*WIDTH +: WIDTH]
//  gnt        out  NREQ         one-hot grant, registered
//  busy       out  1            high in RUN or DONE
//  done       out  1            one-cycle pulse: granted interval completed
//  abort      out  1            one-cycle pulse: grantee dropped req mid-RUN
//  owner      out  $clog2(NREQ) index of current/last grantee
//  count_out  out  WIDTH        shared counter value
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE; gnt=0, busy=0, done=0, abort=0, owner=0,
//   count_out=0, rr pointer=0.
//  FSM states IDLE, RUN, DONE; one transition per clock edge:
//   IDLE: if |req, pick first set req at or after pointer (wrapping modulo NREQ).
//    On that edge: latch len of winner into len_q, gnt<=onehot(winner),
//    owner<=winner, clear counter to 0, ->RUN. Else stay; counter held.
//   RUN: counter increments by 1 each cycle.
//    If req[owner]==0 at an edge: gnt<=0, abort<=1 for one cycle,
//     pointer<=owner+1, ->IDLE; abort takes priority over completion.
//    Else if count_out==len_q: ->DONE, counter holds.
//   DONE: done=1, gnt held; on exit edge gnt<=0, pointer<=owner+1 mod NREQ, ->IDLE.
//  Latency: gnt rises 1 cycle after req sampled in IDLE. RUN lasts len_q+1 cycles
//   (count 0..len_q). done asserts len_q+1 cycles after gnt rises.
//   gnt is high for exactly len_q+2 cycles.
//  len==0 is legal: one RUN cycle, then DONE.
//  len==2^WIDTH-1: counter reaches all-ones, no wrap occurs; counter never wraps
//   while owned.
//  Handshake: requester holds req and len stable until it sees done or abort.
//   len changes after grant are ignored (len_q latched).
//   Requester drops req on the cycle after done. req still high when IDLE is
//   sampled = new request.
//  Back-to-back: at least one IDLE cycle (gnt low) between grants; no grant overlap.
//  Simultaneous requests: lowest index at/after pointer wins. Losers wait; no starvation.
//   Each requester is served within NREQ grants.
//  owner and count_out hold their values in IDLE until the next grant.
//  Reset mid-RUN: all outputs to reset values immediately; no done/abort pulse.
//  gnt is always one-hot or zero. done and abort are never high together.
// STRUCTURE
//  Shared package counter_arbiter_pkg: state encoding localparams (IDLE=2'd0,
//   RUN=2'd1, DONE=2'd2) and an index-width function clog2.
//  Sub-module interval_counter: WIDTH-bit up-counter with sync clear and enable,
//   async active-low reset.
//  Arbiter FSM, rr pointer and len mux stay in counter_arbiter.
// TESTING
//  1 Single: req=4'b0010, len1=3 -> gnt=0010 next cycle, count 0,1,2,3,
//    done pulse with owner=1; gnt high 5 cycles.
//  2 Contention: req=4'b1111 held, all len=1 -> grants in order 0,1,2,3,0;
//    one gnt-low cycle between each.
//  3 Abort: req0, len0=9; drop req0 when count_out==4 -> abort pulse, no done,
//    gnt=0, pointer=1.
//  4 Bounds: len=0 -> done 1 cycle after gnt. len=15 -> count reaches 15,
//    done, no wrap.
//  5 Reset: assert reset when count_out==2 -> outputs 0 asynchronously.
//    After release with req2 high, grant to 2 after one edge.
//  6 Len stability: change len2 after gnt -> completion uses the latched value.
//    Check one-hot gnt and that done and abort are never both high.

Source files
------------

// File: rtl/counter_arbiter_pkg.sv
// Shared definitions for the counter arbiter: FSM state encoding and an
// index-width helper used to size owner/pointer fields.
package counter_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/interval_counter.sv
// WIDTH-bit up-counter with synchronous clear (priority) and enable.
module interval_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one shared interval counter to NREQ
// requesters; the grantee keeps it until its interval completes or it withdraws.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 4,
  localparam int IW    = clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic                  abort,
  output logic [IW-1:0]         owner,
  output logic [WIDTH-1:0]      count_out
);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             abort_q, abort_d;
  logic             cnt_clr, cnt_en;

  logic [IW-1:0]    win, ptr_nx;
  logic [IW:0]      idx;
  logic             found;

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(i);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  assign ptr_nx = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    abort_d = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          owner_d    = win;
          len_d      = len[win*WIDTH +: WIDTH];
          cnt_clr    = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        // Withdrawal wins over completion on the same edge.
        if (!req[owner_q]) begin
          gnt_d   = '0;
          abort_d = 1'b1;
          ptr_d   = ptr_nx;
          state_d = IDLE;
        end else if (count_out == len_q) begin
          state_d = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        gnt_d   = '0;
        ptr_d   = ptr_nx;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      abort_q <= abort_d;
    end
  end

  interval_counter #(.WIDTH(WIDTH)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count_out)
  );

  assign gnt   = gnt_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign abort = abort_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboarded bench for counter_arbiter: expected completions are queued as
// requests are driven and checked when done/abort pulses appear.
module tb_counter_arbiter;

  logic        clock, reset;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  gnt;
  logic        busy, done, abort;
  logic [1:0]  owner;
  logic [3:0]  count_out;

  counter_arbiter #(.NREQ(4), .WIDTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .len       (len),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .abort     (abort),
    .owner     (owner),
    .count_out (count_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       ab;
    logic [1:0] own;
    logic [3:0] cnt;
    int         glen;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input logic ab, input logic [1:0] own, input logic [3:0] cnt, input int glen);
    exp_t e;
    e.ab = ab; e.own = own; e.cnt = cnt; e.glen = glen;
    sb.push_back(e);
  endtask

  task automatic wait_evt(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clock);
      if (done || abort) seen = 1'b1;
    end
    if (!seen) chk("evt_timeout", 0, 1);
  endtask

  task automatic wait_cnt(input logic [3:0] v, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clock);
      if (busy && count_out == v) seen = 1'b1;
    end
    if (!seen) chk("cnt_timeout", 0, 1);
  endtask

  // Completion monitor plus per-cycle grant invariants.
  int         gcnt;
  logic [3:0] pg;
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      gcnt = 0;
      pg   = '0;
    end else begin
      chk("gnt_onehot", {31'd0, $onehot0(gnt)}, 1);
      chk("done_and_abort", {31'd0, done & abort}, 0);
      if (gnt != 0 && pg != 0) chk("gnt_no_overlap", gnt, pg);
      if (gnt != 0) gcnt++;
      if (done || abort) begin
        if (sb.size() == 0) chk("sb_unexpected_evt", 1, 0);
        else begin
          e = sb.pop_front();
          chk("evt_kind_abort", abort, e.ab);
          chk("evt_owner", owner, e.own);
          chk("evt_count", count_out, e.cnt);
          if (!e.ab) chk("gnt_cycles", gcnt, e.glen);
        end
      end
      if (gnt == 0) gcnt = 0;
      pg = gnt;
    end
  end

  initial begin
    reset = 1'b0;
    req   = '0;
    len   = '0;
    repeat (2) @(negedge clock);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", abort, 0);
    chk("rst_owner", owner, 0);
    chk("rst_count", count_out, 0);
    reset = 1'b1;

    // Single request, len1=3
    push_exp(1'b0, 2'd1, 4'd3, 5);
    @(posedge clock); #1;
    req = 4'b0010; len = 16'h0030;
    @(negedge clock);
    chk("t1_no_gnt_yet", gnt, 0);
    @(negedge clock);
    chk("t1_gnt", gnt, 4'b0010);
    chk("t1_owner", owner, 1);
    chk("t1_cnt0", count_out, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      chk("t1_cnt", count_out, c);
      chk("t1_not_done", done, 0);
    end
    @(negedge clock);
    chk("t1_done", done, 1);
    @(posedge clock); #1;
    req = '0;
    @(negedge clock);
    chk("t1_gnt_off", gnt, 0);
    chk("t1_idle", busy, 0);

    // Restart pointer at 0 for the contention sweep
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Contention: all request, len=1
    push_exp(1'b0, 2'd0, 4'd1, 3);
    push_exp(1'b0, 2'd1, 4'd1, 3);
    push_exp(1'b0, 2'd2, 4'd1, 3);
    push_exp(1'b0, 2'd3, 4'd1, 3);
    push_exp(1'b0, 2'd0, 4'd1, 3);
    @(posedge clock); #1;
    req = 4'b1111; len = 16'h1111;
    for (int k = 0; k < 5; k++) wait_evt(40);
    @(posedge clock); #1;
    req = '0;

    // Abort: req0 len9, withdraw at count 4
    push_exp(1'b1, 2'd0, 4'd4, 0);
    @(posedge clock); #1;
    req = 4'b0001; len = 16'h0009;
    wait_cnt(4'd4, 40);
    req = '0;
    @(negedge clock);
    chk("t3_abort", abort, 1);
    chk("t3_no_done", done, 0);
    chk("t3_gnt", gnt, 0);
    @(negedge clock);
    chk("t3_abort_pulse", abort, 0);

    // Pointer now 1: with req0/req1 both up, 1 wins; len=0
    push_exp(1'b0, 2'd1, 4'd0, 2);
    @(posedge clock); #1;
    req = 4'b0011; len = 16'h0000;
    wait_evt(40);
    @(posedge clock); #1;
    req = '0;

    // len=15 on requester 3
    push_exp(1'b0, 2'd3, 4'd15, 17);
    @(posedge clock); #1;
    req = 4'b1000; len = 16'hF000;
    wait_evt(60);
    chk("t4_cnt_max", count_out, 4'hF);
    @(posedge clock); #1;
    req = '0;

    // Reset mid-run
    @(posedge clock); #1;
    req = 4'b0100; len = 16'h0500;
    wait_cnt(4'd2, 40);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_abort", abort, 0);
    chk("t5_rst_owner", owner, 0);
    chk("t5_rst_count", count_out, 0);
    push_exp(1'b0, 2'd2, 4'd5, 7);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_regrant", gnt, 4'b0100);
    chk("t5_owner", owner, 2);

    // Len change after grant must be ignored
    @(posedge clock); #1;
    len = 16'h0100;
    wait_evt(40);
    chk("t6_latched_len", count_out, 5);
    @(posedge clock); #1;
    req = '0;
    repeat (3) @(negedge clock);
    chk("sb_leftover", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
